// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around a single full_adder cell.
// Two WIDTH-bit operands and a carry-in are captured on an accepted start,
// then added one bit per clock (LSB first) through the full_adder, with the
// carry held in a register between bits. The completed sum and carry-out are
// presented on registered outputs, flagged by a one-cycle done pulse.
//
// Timing (WIDTH = N):
//   E0        : start accepted in IDLE, operands captured
//   E1 .. EN  : RUN, bit k processed at edge E(k+1)
//   after EN  : DONE, done = 1, sum/cout hold the new result
//   next edge : back to IDLE (start is ignored in RUN and DONE)

// One-bit full adder: the only adder logic in the design.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Sum and majority-carry of the three input bits.
  always_comb begin
    sum   = a ^ b ^ cin;
    carry = (a & b) | (cin & (a ^ b));
  end

endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Stop elaboration on an unsupported width rather than building a broken
  // datapath: the referenced module deliberately does not exist.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    serial_adder_width_out_of_range u_bad_width ();
  end

  // Bit counter needs to reach WIDTH-1; keep at least one bit for WIDTH = 1.
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operand shift registers: their LSBs feed the full_adder each RUN cycle.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Partial sum: new bits enter at the MSB so that after WIDTH shifts bit 0
  // of the result sits in bit 0.
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_next;
  logic             carry_r;
  logic [CW-1:0]    count;
  logic             last_bit;

  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_r),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (count == LAST);

  // Next partial-sum value; with a single bit there is nothing to shift down.
  if (WIDTH == 1) begin : g_snext_1
    assign s_next = fa_sum;
  end else begin : g_snext_n
    assign s_next = {fa_sum, s_sr[WIDTH-1:1]};
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the last bit,
  // DONE -> IDLE unconditionally.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)    state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:                state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // Output decode: busy and done come straight from the state register, so
  // they are glitch-free and clear together with the state on reset.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture in IDLE, one bit per edge in RUN, result
  // registers loaded only on the completion edge. Reset clears everything,
  // including the visible result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry_r <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_r <= cin;
            count   <= '0;
            s_sr    <= '0;
          end
        end
        S_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          s_sr    <= s_next;
          carry_r <= fa_carry;
          count   <= count + CW'(1);
          if (last_bit) begin
            sum  <= s_next;
            cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
